// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead helper for the pipelined CLA adder.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  // Returns {c4, c3, c2, c1, c0}. Every carry is a sum of products of p/g/ci,
  // so none of them waits on a lower carry inside the group.
  function automatic logic [4:0] cla_group_carry(input logic [3:0] p4,
                                                 input logic [3:0] g4,
                                                 input logic       ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g4[0] | (p4[0] & ci);
    c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
    c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
         | (p4[2] & p4[1] & p4[0] & ci);
    c[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0])
         | (p4[3] & p4[2] & p4[1] & p4[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// Combinational 4-bit lookahead block: bit P/G and group carry-in in,
// internal carries c[4:1] and group propagate/generate out.
module cla_lookahead4
  import cla_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [4:1] c,
  output logic       gp,
  output logic       gg
);

  logic unused_c0;

  assign {c, unused_c0} = cla_group_carry(p, g, ci);

  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage valid/ready carry-lookahead adder: stage 1 registers P/G, stage 2 the sum.
// Optional signed-overflow output enabled by defining CLA_OVF_FLAG_EN.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d3,
  output logic             d4
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGRP = WIDTH / CLA_GROUP;

  cla_pg_t [WIDTH-1:0] s1_pg;
  logic                s1_cin;
  logic                s1_valid;
  logic                s1_adv;
  logic                s2_adv;
  logic                in_xfer;
  logic [WIDTH-1:0]    pv;
  logic [WIDTH-1:0]    gv;
  logic [WIDTH:0]      c;
  logic [NGRP-1:0]     grp_p;
  logic [NGRP-1:0]     grp_g;
  logic [NGRP-1:0]     grp_ci;
  logic                unused_grp;
`ifdef CLA_OVF_FLAG_EN
  logic                s1_smis;
`endif

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && s1_adv;

  // Data registers load only on a transfer so idle operands never propagate.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pg    <= '0;
      s1_cin   <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      s1_smis  <= 1'b0;
`endif
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (in_xfer) begin
        for (int i = 0; i < WIDTH; i++) begin
          s1_pg[i] <= '{p: a[i] ^ b[i], g: a[i] & b[i]};
        end
        s1_cin <= cin;
`ifdef CLA_OVF_FLAG_EN
        s1_smis <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_unpack
    assign pv[i] = s1_pg[i].p;
    assign gv[i] = s1_pg[i].g;
  end

  assign c[0]      = s1_cin;
  assign grp_ci[0] = s1_cin;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla_lookahead4 u_la (
      .p  (pv[CLA_GROUP*gi +: CLA_GROUP]),
      .g  (gv[CLA_GROUP*gi +: CLA_GROUP]),
      .ci (grp_ci[gi]),
      .c  (c[CLA_GROUP*gi+1 +: CLA_GROUP]),
      .gp (grp_p[gi]),
      .gg (grp_g[gi])
    );
    // Group-level P/G ripples the carry into the next group.
    if (gi < NGRP - 1) begin : g_ripple
      assign grp_ci[gi+1] = grp_g[gi] | (grp_p[gi] & grp_ci[gi]);
    end
  end

  // Top group's P/G would only feed a carry-in beyond the MSB; c[WIDTH] covers it.
  assign unused_grp = grp_p[NGRP-1] ^ grp_g[NGRP-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      d3        <= '0;
      d4        <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        d3 <= pv ^ c[WIDTH-1:0];
        d4 <= c[WIDTH];
`ifdef CLA_OVF_FLAG_EN
        // Mismatched signs force c[WIDTH]==c[WIDTH-1]; the gate only makes that explicit.
        ovf <= !s1_smis && (c[WIDTH] ^ c[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed table, stall/reset sequences,
// and random traffic on a 4-bit and an 8-bit instance. Honours CLA_OVF_FLAG_EN.
module tb_cla_adder_pipe;

  localparam int W     = 4;
  localparam int W8    = 8;
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, in_ready, cin, out_valid, out_ready, d4;
  logic [W-1:0]  a, b, d3;
  logic          reset8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, d4_8;
  logic [W8-1:0] a8, b8, d3_8;
`ifdef CLA_OVF_FLAG_EN
  logic          ovf, ovf8;
`endif

  cla_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .d3(d3), .d4(d4)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  cla_adder_pipe #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .d3(d3_8), .d4(d4_8)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf8)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  logic w8_done = 1'b0;

  exp_t         sb[$];
  logic         stall_prev;
  logic [W-1:0] held_d3;
  logic         held_d4, held_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model4(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
    return e;
  endfunction

  // One clock of the 4-bit instance: drive at negedge, evaluate, scoreboard push/pop.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic ordy, input exp_t ex, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = iv ? ia : 'x;
    b         = iv ? ib : 'x;
    cin       = iv ? ic : 1'bx;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("stall_d3", d3, held_d3);
      check("stall_d4", d4, held_d4);
`ifdef CLA_OVF_FLAG_EN
      check("stall_ovf", ovf, held_ovf);
`endif
    end
    stall_prev = out_valid && !out_ready;
    held_d3    = d3;
    held_d4    = d4;
`ifdef CLA_OVF_FLAG_EN
    held_ovf   = ovf;
`else
    held_ovf   = 1'b0;
`endif
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("d3", d3, e.sum);
        check("d4", d4, e.cout);
`ifdef CLA_OVF_FLAG_EN
        check("ovf", ovf, e.ovf);
`endif
      end
    end
    acc = iv && in_ready;
    if (acc) sb.push_back(ex);
  endtask

  initial begin : main
    vec_t         tbl[11];
    logic [W-1:0] bpa[3], bpb[3];
    logic         bpc[3];
    logic         acc, iv, ordy;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           k, idx, n;

    // First three rows are the back-to-back sequence; the ovf rows follow.
    tbl[0]  = '{a: 4'h3, b: 4'h4, cin: 1'b0, sum: 4'h7, cout: 1'b0, ovf: 1'b0};
    tbl[1]  = '{a: 4'h9, b: 4'h9, cin: 1'b1, sum: 4'h3, cout: 1'b1, ovf: 1'b1};
    tbl[2]  = '{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 4'hF, cout: 1'b1, ovf: 1'b0};
    tbl[3]  = '{a: 4'h7, b: 4'h1, cin: 1'b0, sum: 4'h8, cout: 1'b0, ovf: 1'b1};
    tbl[4]  = '{a: 4'h8, b: 4'h8, cin: 1'b0, sum: 4'h0, cout: 1'b1, ovf: 1'b1};
    tbl[5]  = '{a: 4'h3, b: 4'h2, cin: 1'b0, sum: 4'h5, cout: 1'b0, ovf: 1'b0};
    tbl[6]  = '{a: 4'h5, b: 4'hA, cin: 1'b1, sum: 4'h0, cout: 1'b1, ovf: 1'b0};
    tbl[7]  = '{a: 4'h0, b: 4'h0, cin: 1'b1, sum: 4'h1, cout: 1'b0, ovf: 1'b0};
    tbl[8]  = '{a: 4'h0, b: 4'h0, cin: 1'b0, sum: 4'h0, cout: 1'b0, ovf: 1'b0};
    tbl[9]  = '{a: 4'h7, b: 4'h7, cin: 1'b1, sum: 4'hF, cout: 1'b0, ovf: 1'b1};
    tbl[10] = '{a: 4'hE, b: 4'h3, cin: 1'b0, sum: 4'h1, cout: 1'b1, ovf: 1'b0};

    bpa[0] = 4'h1; bpb[0] = 4'h2; bpc[0] = 1'b0;
    bpa[1] = 4'h6; bpb[1] = 4'h6; bpc[1] = 1'b0;
    bpa[2] = 4'hA; bpb[2] = 4'hB; bpc[2] = 1'b1;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    stall_prev = 1'b0; held_d3 = '0; held_d4 = 1'b0; held_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_d3", d3, 0);
    check("rst_d4", d4, 0);
`ifdef CLA_OVF_FLAG_EN
    check("rst_ovf", ovf, 0);
`endif
    reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // Single beat, exact two-clock latency.
    cycle(1'b1, 4'hF, 4'h1, 1'b0, 1'b1, '{sum: 4'h0, cout: 1'b1, ovf: 1'b0}, acc);
    check("single_accept", acc, 1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("single_lat1_valid", out_valid, 0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("single_lat2_valid", out_valid, 1);
    check("single_drained", sb.size(), 0);

    // Table rows back-to-back with no stall: every beat accepted, drained in 2 clk.
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1,
            '{sum: tbl[i].sum, cout: tbl[i].cout, ovf: tbl[i].ovf}, acc);
      check("tbl_accept", acc, 1);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("tbl_drained", sb.size(), 0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("tbl_idle_valid", out_valid, 0);

    // Backpressure: 3 beats offered over 4 stalled clocks, only 2 fit.
    k = 0;
    for (int i = 0; i < 4; i++) begin
      idx = (k < 3) ? k : 0;
      cycle(k < 3, bpa[idx], bpb[idx], bpc[idx], 1'b0, model4(bpa[idx], bpb[idx], bpc[idx]), acc);
      if (acc) k++;
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 8; i++) begin
      idx = (k < 3) ? k : 0;
      cycle(k < 3, bpa[idx], bpb[idx], bpc[idx], 1'b1, model4(bpa[idx], bpb[idx], bpc[idx]), acc);
      if (acc) k++;
    end
    check("bp_all_accepted", k, 3);
    check("bp_drained", sb.size(), 0);

    // Reset with two beats in flight: nothing from before reset may appear.
    cycle(1'b1, 4'h5, 4'h6, 1'b0, 1'b0, model4(4'h5, 4'h6, 1'b0), acc);
    cycle(1'b1, 4'h9, 4'h2, 1'b1, 1'b0, model4(4'h9, 4'h2, 1'b1), acc);
    check("mid_two_in_flight", sb.size(), 2);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_d3", d3, 0);
      check("mid_rst_d4", d4, 0);
    end
    reset = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    #1 check("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
      check("mid_no_stale", out_valid, 0);
    end

    // Random traffic on the 4-bit instance.
    n = 0;
    for (int cyc = 0; cyc < NRAND * 4 && n < NRAND; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      cycle(iv, ra, rb, rc, ordy, model4(ra, rb, rc), acc);
      if (acc) n++;
    end
    check("rand4_beats", n, NRAND);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("rand4_drained", sb.size(), 0);

    for (int i = 0; i < 50000 && !w8_done; i++) @(posedge clk);
    check("rand8_finished", w8_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : rand8
    logic [W8:0]   sb8[$];
    logic [W8:0]   e8;
    logic          sb8_ovf[$];
    logic          eo8;
    logic [W8-1:0] ra8, rb8, hd3;
    logic          rc8, iv8, hd4, ho8, sp8;
    int            n8;

    n8 = 0; sp8 = 1'b0; hd3 = '0; hd4 = 1'b0; ho8 = 1'b0;
    reset8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset8 = 1'b0;
    for (int cyc = 0; cyc < NRAND * 4 + 8; cyc++) begin
      @(negedge clk);
      iv8        = (n8 < NRAND) && ($urandom_range(0, 3) != 0);
      ra8        = W8'($urandom);
      rb8        = W8'($urandom);
      rc8        = 1'($urandom);
      in_valid8  = iv8;
      a8         = iv8 ? ra8 : 'x;
      b8         = iv8 ? rb8 : 'x;
      cin8       = iv8 ? rc8 : 1'bx;
      out_ready8 = (n8 >= NRAND) || ($urandom_range(0, 3) != 0);
      #1;
      if (sp8) begin
        check("w8_stall_d3", d3_8, hd3);
        check("w8_stall_d4", d4_8, hd4);
`ifdef CLA_OVF_FLAG_EN
        check("w8_stall_ovf", ovf8, ho8);
`endif
      end
      sp8 = out_valid8 && !out_ready8;
      hd3 = d3_8;
      hd4 = d4_8;
`ifdef CLA_OVF_FLAG_EN
      ho8 = ovf8;
`endif
      if (out_valid8 && out_ready8) begin
        if (sb8.size() == 0) begin
          check("w8_unexpected_out", out_valid8, 0);
        end else begin
          e8  = sb8.pop_front();
          eo8 = sb8_ovf.pop_front();
          check("w8_sum", {d4_8, d3_8}, e8);
`ifdef CLA_OVF_FLAG_EN
          check("w8_ovf", ovf8, eo8);
`endif
        end
      end
      if (iv8 && in_ready8) begin
        e8 = {1'b0, ra8} + {1'b0, rb8} + {{W8{1'b0}}, rc8};
        sb8.push_back(e8);
        sb8_ovf.push_back((ra8[W8-1] == rb8[W8-1]) && (e8[W8-1] != ra8[W8-1]));
        n8++;
      end
      if (n8 >= NRAND && sb8.size() == 0) break;
    end
    check("w8_beats", n8, NRAND);
    check("w8_drained", sb8.size(), 0);
    w8_done = 1'b1;
  end

endmodule
